// File: rtl/polyvecl_pointwise_acc.sv
// polyvecl_pointwise_acc: w[j] = sum_i montgomery_reduce(u_i[j]*v_i[j]), LANES coeffs/cycle.
// Define FINAL_REDUCE_EN to apply reduce32 to each coefficient when the result is published.
module polyvecl_pointwise_acc #(
  parameter int L     = 5,
  parameter int LANES = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [L*8192-1:0]   u_in,
  input  logic [L*8192-1:0]   v_in,
  output logic [8191:0]       w_out,
  output logic                done
);
  localparam int NCH = 256 / LANES;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = (L > 1) ? $clog2(L) : 1;
  typedef enum logic [2:0] {IDLE, WAIT_START, LOAD, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic done_q, done_d;
  logic drain_q, drain_d;
  logic s1_valid_q, s1_valid_d;
  logic [CW-1:0] chunk_q, chunk_d, s1_chunk_q, s1_chunk_d;
  logic [PW-1:0] poly_q, poly_d;
  logic signed [31:0] u_q [L][256];
  logic signed [31:0] u_d [L][256];
  logic signed [31:0] v_q [L][256];
  logic signed [31:0] v_d [L][256];
  logic signed [31:0] acc_q [256];
  logic signed [31:0] acc_d [256];
  logic signed [31:0] w_q [256];
  logic signed [31:0] w_d [256];
  logic signed [63:0] prod_q [LANES];
  logic signed [63:0] prod_d [LANES];
  function automatic logic signed [63:0] mul(input logic signed [31:0] x, input logic signed [31:0] y);
    return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
  endfunction
  // Low 32 bits of (a - t*Q) are zero by construction of t, so the upper half is the exact shift.
  function automatic logic signed [31:0] mont(input logic signed [63:0] a);
    logic [31:0] t;
    logic signed [63:0] d;
    t = a[31:0] * 32'd58728449;
    d = a - $signed({{32{t[31]}}, t}) * 64'sd8380417;
    return d[63:32];
  endfunction
  function automatic logic signed [31:0] red32(input logic signed [31:0] a);
    logic signed [31:0] t;
    t = (a + 32'sd4194304) >>> 23;
    return a - t * 32'sd8380417;
  endfunction
  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    drain_d    = drain_q;
    poly_d     = poly_q;
    chunk_d    = chunk_q;
    s1_valid_d = 1'b0;
    s1_chunk_d = s1_chunk_q;
    u_d        = u_q;
    v_d        = v_q;
    acc_d      = acc_q;
    w_d        = w_q;
    prod_d     = prod_q;
    if (s1_valid_q)
      for (int k = 0; k < LANES; k++)
        acc_d[8'(int'(s1_chunk_q) * LANES + k)] = acc_q[8'(int'(s1_chunk_q) * LANES + k)] + mont(prod_q[k]);
    case (state_q)
      IDLE: begin
        state_d = WAIT_START;
        done_d  = 1'b0;
      end
      WAIT_START: state_d = start ? LOAD : WAIT_START;
      LOAD: begin
        for (int i = 0; i < L; i++)
          for (int j = 0; j < 256; j++) begin
            u_d[i][j] = u_in[8192*i + 32*j +: 32];
            v_d[i][j] = v_in[8192*i + 32*j +: 32];
          end
        for (int j = 0; j < 256; j++) acc_d[j] = '0;
        poly_d  = '0;
        chunk_d = '0;
        state_d = RUN;
      end
      RUN: begin
        s1_valid_d = 1'b1;
        s1_chunk_d = chunk_q;
        for (int k = 0; k < LANES; k++)
          prod_d[k] = mul(u_q[poly_q][8'(int'(chunk_q) * LANES + k)], v_q[poly_q][8'(int'(chunk_q) * LANES + k)]);
        chunk_d = (int'(chunk_q) == NCH - 1) ? '0 : chunk_q + 1'b1;
        if (int'(chunk_q) == NCH - 1) begin
          poly_d  = (int'(poly_q) == L - 1) ? poly_q : poly_q + 1'b1;
          state_d = (int'(poly_q) == L - 1) ? DRAIN : RUN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          for (int j = 0; j < 256; j++)
`ifdef FINAL_REDUCE_EN
            w_d[j] = red32(acc_q[j]);
`else
            w_d[j] = acc_q[j];
`endif
        end
      end
      DONE: begin
        state_d = start ? DONE : IDLE;
        done_d  = start;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      drain_q    <= 1'b0;
      poly_q     <= '0;
      chunk_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_chunk_q <= '0;
      for (int j = 0; j < 256; j++) begin
        acc_q[j] <= '0;
        w_q[j]   <= '0;
      end
      for (int i = 0; i < L; i++)
        for (int j = 0; j < 256; j++) begin
          u_q[i][j] <= '0;
          v_q[i][j] <= '0;
        end
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      drain_q    <= drain_d;
      poly_q     <= poly_d;
      chunk_q    <= chunk_d;
      s1_valid_q <= s1_valid_d;
      s1_chunk_q <= s1_chunk_d;
      acc_q      <= acc_d;
      w_q        <= w_d;
      u_q        <= u_d;
      v_q        <= v_d;
      prod_q     <= prod_d;
    end
  for (genvar g = 0; g < 256; g++) begin : g_w
    assign w_out[32*g +: 32] = w_q[g];
  end
  assign done = done_q;
endmodule

// File: tb/tb_polyvecl_pointwise_acc.sv
// tb_polyvecl_pointwise_acc: directed jobs checked against a Dilithium-style golden model.
module tb_polyvecl_pointwise_acc;
  localparam int L = 5;
  localparam int LANES = 8;
  localparam int LAT = 3 + L * 256 / LANES;
  logic clock = 0, reset = 1, start = 0, done;
  logic [L*8192-1:0] u_in = '0, v_in = '0;
  logic [8191:0] w_out, exp_w, exp_pending;
  logic exp_done;
  int n_tests = 0, n_fail = 0;
  int phase, cnt;
  polyvecl_pointwise_acc #(.L(L), .LANES(LANES)) dut (
    .clock(clock), .reset(reset), .start(start),
    .u_in(u_in), .v_in(v_in), .w_out(w_out), .done(done));
  always #5 clock = ~clock;
  function automatic int mont(input longint a);
    int t;
    t = int'(a * 64'sd58728449);
    return int'((a - longint'(t) * 64'sd8380417) >>> 32);
  endfunction
  function automatic int red32(input int a);
    int t;
    t = (a + (1 << 22)) >>> 23;
    return a - t * 8380417;
  endfunction
  function automatic logic [8191:0] golden(input logic [L*8192-1:0] u, input logic [L*8192-1:0] v);
    logic [8191:0] w;
    int acc, a, b;
    for (int j = 0; j < 256; j++) begin
      acc = 0;
      for (int i = 0; i < L; i++) begin
        a = u[8192*i + 32*j +: 32];
        b = v[8192*i + 32*j +: 32];
        acc += mont(longint'(a) * longint'(b));
      end
`ifdef FINAL_REDUCE_EN
      acc = red32(acc);
`endif
      w[32*j +: 32] = acc;
    end
    return w;
  endfunction
  function automatic logic [L*8192-1:0] rand_vec();
    logic [L*8192-1:0] r;
    for (int k = 0; k < L * 256; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [31:0] wc(input int j);
    return w_out[32*j +: 32];
  endfunction
  // Job-level model: start seen while waiting, inputs captured one edge later, result after LAT edges.
  always @(posedge clock or posedge reset)
    if (reset) begin
      phase = 0; cnt = 0; exp_done = 0; exp_w = '0; exp_pending = '0;
    end else
      case (phase)
        0: phase = 1;
        1: if (start) begin phase = 2; cnt = 0; end
        2: begin
          cnt++;
          if (cnt == 1) exp_pending = golden(u_in, v_in);
          if (cnt == LAT) begin exp_w = exp_pending; exp_done = 1; phase = 3; end
        end
        default: if (!start) begin exp_done = 0; phase = 0; end
      endcase
  always @(negedge clock)
    if (!reset) begin
      n_tests++;
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL cmp_done t=%0t: got %b expected %b", $time, done, exp_done);
      end
      n_tests++;
      if (w_out !== exp_w) begin
        n_fail++;
        for (int j = 0; j < 256; j++)
          if (w_out[32*j +: 32] !== exp_w[32*j +: 32]) begin
            $display("FAIL cmp_w t=%0t: coeff %0d got %0d expected %0d", $time, j,
                     $signed(w_out[32*j +: 32]), $signed(exp_w[32*j +: 32]));
            break;
          end
      end
    end
  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, $signed(got), got, $signed(exp), exp);
    end
  endtask
  task automatic run_job(input logic [L*8192-1:0] u, input logic [L*8192-1:0] v,
                         input bit scramble, input int hold);
    int lat;
    start = 0;
    repeat (2) @(negedge clock);
    u_in = u; v_in = v; start = 1;
    @(posedge clock);
    lat = 0;
    do begin
      @(posedge clock); lat++; #1;
      if (scramble) begin u_in = rand_vec(); v_in = rand_vec(); end
    end while (!done && lat < 300);
    check32("latency", lat, LAT);
    repeat (hold) @(posedge clock);
    #1 check32("done_hold", {31'b0, done}, 1);
    start = 0;
    @(posedge clock);
    #1 check32("done_fall", {31'b0, done}, 0);
  endtask
  initial begin
    logic [L*8192-1:0] u, v;
    logic [8191:0] g;
    bit in_range;
    int c;
    repeat (3) @(negedge clock);
    reset = 0;
    check32("model_mont_one", mont(64'sd4193792), 1);
    check32("model_mont_neg3", mont(-64'sd3 * 64'sd4193792), -3);
    // all-zero job, start held ~200 cycles
    run_job('0, '0, 0, 36);
    check32("zero_w0", wc(0), 0);
    check32("zero_w255", wc(255), 0);
    // u = 2^32 mod Q, v_i[j] = j+1 -> w[j] = 5*(j+1)
    for (int i = 0; i < L; i++)
      for (int j = 0; j < 256; j++) begin
        u[8192*i + 32*j +: 32] = 32'd4193792;
        v[8192*i + 32*j +: 32] = 32'(j + 1);
      end
    run_job(u, v, 0, 2);
    check32("scale_w0", wc(0), 5);
    check32("scale_w100", wc(100), 505);
    check32("scale_w255", wc(255), 1280);
    // single negative coefficient
    u = '0; v = '0;
    u[31:0] = 32'd4193792;
    v[31:0] = 32'hFFFFFFFD;
    run_job(u, v, 0, 1);
    check32("neg_w0", wc(0), 32'hFFFFFFFD);
    check32("neg_w1", wc(1), 0);
    // all Q-1
    for (int k = 0; k < L * 256; k++) begin
      u[32*k +: 32] = 32'd8380416;
      v[32*k +: 32] = 32'd8380416;
    end
    run_job(u, v, 0, 1);
`ifdef FINAL_REDUCE_EN
    in_range = 1;
    for (int j = 0; j < 256; j++) begin
      c = wc(j);
      if (c < -6283009 || c > 6283008) in_range = 0;
    end
    check32("reduce32_range", {31'b0, in_range}, 1);
`endif
    // full-range random
    run_job(rand_vec(), rand_vec(), 0, 1);
    // asynchronous reset in the middle of RUN
    repeat (2) @(negedge clock);
    u_in = rand_vec(); v_in = rand_vec(); start = 1;
    @(posedge clock);
    @(posedge clock);
    repeat (50) @(posedge clock);
    #2 reset = 1;
    #1 check32("rst_done", {31'b0, done}, 0);
    check32("rst_w_nonzero", {31'b0, |w_out}, 0);
    start = 0;
    @(negedge clock) reset = 0;
    run_job(rand_vec(), rand_vec(), 0, 1);
    // inputs scrambled every cycle after LOAD
    u = rand_vec(); v = rand_vec();
    g = golden(u, v);
    run_job(u, v, 1, 1);
    for (int j = 0; j < 256; j++) begin
      if (w_out[32*j +: 32] !== g[32*j +: 32] || j == 255) begin
        check32("scramble_w", wc(j), g[32*j +: 32]);
        break;
      end
    end
    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
